ser_rx8: RTL and testbench

SER_RX8 -- requirements
Module: ser_rx8

---
 rtl/ser_pkg.sv | 15 +
 rtl/bit_timer.sv | 27 ++
 rtl/ser_rx8.sv | 118 +++++++++++
 tb/tb_ser_rx8.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared constants for the 8N1 serial receiver: FSM encoding, default bit
// period and frame length.
package ser_pkg;

  localparam int DIV_DEF    = 4;
  localparam int FRAME_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter. tc marks a sampling point. In half mode the first
// sample lands DIV/2 cycles after the line first reads low, because the
// IDLE detect edge has already used up one of those cycles.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic C,
  input  logic R,
  input  logic load,
  input  logic half,
  output logic tc
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] FULL_LIM = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LIM = CW'(DIV / 2 - 2);

  logic [CW-1:0] cnt;

  assign tc = (cnt == (half ? HALF_LIM : FULL_LIM));

  always_ff @(posedge C) begin
    if (R || load || tc) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/ser_rx8.sv
// 8N1 serial receiver with a one-byte holding register, a valid/ack
// handshake and sticky framing/overrun flags.
module ser_rx8
  import ser_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic       C,
  input  logic       R,
  input  logic       SI,
  input  logic       ACK,
  input  logic       CLR,
  output logic [7:0] Q,
  output logic       VALID,
  output logic       FERR,
  output logic       OVR,
  output logic       BUSY
);

  state_t     state;
  logic       s1, ss;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic       stop_bit;
  logic       fin;
  logic       tc;

  bit_timer #(.DIV(DIV)) u_timer (
    .C    (C),
    .R    (R),
    .load (state == IDLE),
    .half (state == START),
    .tc   (tc)
  );

  // The synchroniser resets to the idle level so reset release cannot fake a start bit.
  always_ff @(posedge C) begin
    if (R) begin
      s1 <= 1'b1;
      ss <= 1'b1;
    end else begin
      s1 <= SI;
      ss <= s1;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state    <= IDLE;
      idx      <= '0;
      shreg    <= '0;
      stop_bit <= 1'b0;
      fin      <= 1'b0;
      Q        <= 8'h00;
      VALID    <= 1'b0;
      FERR     <= 1'b0;
      OVR      <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (CLR) begin
        FERR <= 1'b0;
        OVR  <= 1'b0;
      end
      if (VALID && ACK) VALID <= 1'b0;

      unique case (state)
        IDLE: begin
          if (!ss) begin
            state <= START;
            BUSY  <= 1'b1;
          end
        end
        START: begin
          if (tc) begin
            if (ss) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end
        end
        DATA: begin
          if (tc) begin
            shreg[idx] <= ss;
            idx        <= idx + 3'd1;
            if (idx == 3'(FRAME_BITS - 1)) state <= STOP;
          end
        end
        STOP: begin
          // Stop bit is captured first; the frame is retired on the following edge.
          if (fin) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            if (!stop_bit) begin
              FERR <= 1'b1;
            end else if (!VALID || ACK) begin
              Q     <= shreg;
              VALID <= 1'b1;
            end else begin
              OVR <= 1'b1;
            end
          end else if (tc) begin
            stop_bit <= ss;
            fin      <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_rx8.sv
// Directed bench for ser_rx8 at DIV=4: table of whole frames plus
// hand-written sequences for latency, glitch, break, reset and back-to-back.
module tb_ser_rx8;

  localparam int DIV = 4;

  logic       C, R, SI, ACK, CLR;
  logic [7:0] Q;
  logic       VALID, FERR, OVR, BUSY;

  int checks = 0;
  int errors = 0;

  ser_rx8 #(.DIV(DIV)) dut (
    .C     (C),
    .R     (R),
    .SI    (SI),
    .ACK   (ACK),
    .CLR   (CLR),
    .Q     (Q),
    .VALID (VALID),
    .FERR  (FERR),
    .OVR   (OVR),
    .BUSY  (BUSY)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; returns 40 edges later with the line idle.
  task automatic send(input logic [7:0] d, input logic stopb);
    logic [9:0] bits;
    bits = {stopb, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      SI = bits[i];
      repeat (DIV) @(posedge C);
      #1;
    end
    SI = 1'b1;
  endtask

  task automatic do_reset();
    R = 1'b1;
    @(posedge C); #1;
    R = 1'b0;
    repeat (2) @(posedge C);
    #1;
  endtask

  typedef struct {
    int         pre;   // 0 none, 1 CLR pulse, 2 reset
    logic [7:0] d;
    logic       stopb;
    logic       ack;   // ACK held on the accepting edge
    logic [7:0] eq;
    logic       ev, ef, eo;
  } vec_t;

  vec_t vt[8];
  logic [7:0] got[2];

  initial begin
    vt[0] = '{2, 8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vt[1] = '{0, 8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
    vt[2] = '{2, 8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vt[3] = '{0, 8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};
    vt[4] = '{0, 8'h3C, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0};
    vt[5] = '{1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vt[6] = '{2, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vt[7] = '{0, 8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1, 1'b0};

    R = 1'b1; SI = 1'b1; ACK = 1'b0; CLR = 1'b0;
    repeat (3) @(posedge C);
    @(negedge C);
    chk("rst_q", 32'(Q), 32'h00);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_ferr", 32'(FERR), 32'd0);
    chk("rst_ovr", 32'(OVR), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    @(posedge C); #1;
    R = 1'b0;
    repeat (3) @(posedge C);
    #1;

    // Exact latency: VALID must still be low one edge before cycle 41.
    send(8'hA5, 1'b1);
    @(negedge C);
    chk("lat_valid_early", 32'(VALID), 32'd0);
    chk("lat_busy_early", 32'(BUSY), 32'd1);
    @(negedge C);
    chk("lat_valid", 32'(VALID), 32'd1);
    chk("lat_q", 32'(Q), 32'hA5);
    chk("lat_busy", 32'(BUSY), 32'd0);
    repeat (8) @(posedge C);
    #1;

    for (int i = 0; i < 8; i++) begin
      if (vt[i].pre == 1) begin
        CLR = 1'b1;
        @(posedge C); #1;
        CLR = 1'b0;
      end else if (vt[i].pre == 2) begin
        do_reset();
      end
      send(vt[i].d, vt[i].stopb);
      ACK = vt[i].ack;
      @(posedge C); #1;
      ACK = 1'b0;
      @(negedge C);
      chk($sformatf("v%0d_q", i), 32'(Q), 32'(vt[i].eq));
      chk($sformatf("v%0d_valid", i), 32'(VALID), 32'(vt[i].ev));
      chk($sformatf("v%0d_ferr", i), 32'(FERR), 32'(vt[i].ef));
      chk($sformatf("v%0d_ovr", i), 32'(OVR), 32'(vt[i].eo));
      chk($sformatf("v%0d_busy", i), 32'(BUSY), 32'd0);
      repeat (8) @(posedge C);
      #1;
    end

    CLR = 1'b1;
    @(posedge C); #1;
    CLR = 1'b0;
    @(negedge C);
    chk("clr_ferr", 32'(FERR), 32'd0);
    chk("clr_valid_kept", 32'(VALID), 32'd1);
    @(posedge C); #1;
    ACK = 1'b1;
    @(posedge C); #1;
    ACK = 1'b0;
    @(negedge C);
    chk("ack_valid", 32'(VALID), 32'd0);
    chk("ack_q_held", 32'(Q), 32'h81);
    @(posedge C); #1;

    // Load VALID and FERR, then abandon a frame with reset at bit 3.
    send(8'h44, 1'b1);
    repeat (8) @(posedge C); #1;
    send(8'h3C, 1'b0);
    repeat (8) @(posedge C); #1;
    SI = 1'b0;
    repeat (4) @(posedge C); #1;
    SI = 1'b1;
    repeat (14) @(posedge C);
    @(negedge C);
    chk("mid_busy_before", 32'(BUSY), 32'd1);
    chk("mid_valid_before", 32'(VALID), 32'd1);
    R = 1'b1;
    @(posedge C); #1;
    R = 1'b0;
    @(negedge C);
    chk("mid_busy", 32'(BUSY), 32'd0);
    chk("mid_valid", 32'(VALID), 32'd0);
    chk("mid_ferr", 32'(FERR), 32'd0);
    chk("mid_ovr", 32'(OVR), 32'd0);
    chk("mid_q", 32'(Q), 32'h00);
    repeat (60) @(posedge C);
    @(negedge C);
    chk("mid_after_valid", 32'(VALID), 32'd0);
    chk("mid_after_busy", 32'(BUSY), 32'd0);
    @(posedge C); #1;

    // One-cycle low pulse: START entered then rejected.
    SI = 1'b0;
    @(posedge C); #1;
    SI = 1'b1;
    repeat (2) @(posedge C);
    @(negedge C);
    chk("glitch_busy_seen", 32'(BUSY), 32'd1);
    repeat (3) @(posedge C);
    @(negedge C);
    chk("glitch_busy", 32'(BUSY), 32'd0);
    chk("glitch_valid", 32'(VALID), 32'd0);
    chk("glitch_ferr", 32'(FERR), 32'd0);
    @(posedge C); #1;

    // Line break: framing error, then immediate re-entry to START.
    SI = 1'b0;
    repeat (41) @(posedge C);
    @(negedge C);
    chk("brk_ferr", 32'(FERR), 32'd1);
    chk("brk_valid", 32'(VALID), 32'd0);
    chk("brk_busy_gap", 32'(BUSY), 32'd0);
    @(negedge C);
    chk("brk_restart", 32'(BUSY), 32'd1);
    @(posedge C); #1;
    SI = 1'b1;
    do_reset();
    repeat (4) @(posedge C); #1;

    // Back-to-back frames, each acknowledged one cycle after VALID.
    fork
      begin
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
      end
      begin
        for (int n = 0; n < 2; n++) begin
          int waited;
          waited = 0;
          @(negedge C);
          while (!VALID && waited < 200) begin
            @(negedge C);
            waited++;
          end
          chk($sformatf("b2b%0d_seen", n), 32'(VALID), 32'd1);
          got[n] = Q;
          @(posedge C); #1;
          ACK = 1'b1;
          @(posedge C); #1;
          ACK = 1'b0;
          @(negedge C);
          chk($sformatf("b2b%0d_acked", n), 32'(VALID), 32'd0);
        end
      end
    join
    chk("b2b_first", 32'(got[0]), 32'h00);
    chk("b2b_second", 32'(got[1]), 32'hFF);
    chk("b2b_ferr", 32'(FERR), 32'd0);
    chk("b2b_ovr", 32'(OVR), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
